// File: rtl/count_stream_monitor_if.sv
// Event stream handshake between the count monitor and its consumer.
// The monitor drives the master side; the consumer drives ev_ready.
interface count_stream_monitor_if #(
   parameter int WIDTH = 4
);
   logic             ev_valid;
   logic             ev_ready;
   logic [WIDTH+1:0] ev_data;

   modport master (output ev_valid, output ev_data, input ev_ready);
   modport slave  (input ev_valid, input ev_data, output ev_ready);
endinterface

// File: rtl/count_stream_monitor.sv
// Samples a foreign-clock counter, filters transition skew, classifies each
// accepted change (step/wrap/clear/error) and queues it in a small event FIFO.
module count_stream_monitor #(
   parameter int WIDTH         = 4,
   parameter int STABLE_CYCLES = 3,
   parameter int FIFO_DEPTH    = 4,
   parameter int WRAPW         = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WIDTH-1:0]        cnt_in,
   input  logic                    clr_stats,
   count_stream_monitor_if.master  ev_if,
   output logic [WRAPW-1:0]        wrap_count,
   output logic                    err_sticky,
   output logic                    ovf_sticky
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = WIDTH + 2;

   localparam logic [SW-1:0]    STAB_SAT = SW'(STABLE_CYCLES);
   localparam logic [SW-1:0]    STAB_ACC = SW'(STABLE_CYCLES - 1);
   localparam logic [WIDTH-1:0] MAXV     = {WIDTH{1'b1}};

   localparam logic [1:0] KIND_STEP  = 2'b00;
   localparam logic [1:0] KIND_WRAP  = 2'b01;
   localparam logic [1:0] KIND_CLEAR = 2'b10;
   localparam logic [1:0] KIND_ERROR = 2'b11;

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_cand;
   logic [WIDTH-1:0] r_last;
   logic [SW-1:0]    r_stab;

   logic [EW-1:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;

   logic [WRAPW-1:0] r_wrap;
   logic             r_err;
   logic             r_ovf;

   logic             w_accept;
   logic [1:0]       w_kind;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;

   // A value is accepted exactly once, on the edge its stable run completes.
   assign w_accept = (r_s2 == r_cand) && (r_stab == STAB_ACC) && (r_cand != r_last);

   always_comb begin
      w_kind = KIND_ERROR;
      if (r_last == MAXV && r_cand == '0)
         w_kind = KIND_WRAP;
      else if (r_cand == WIDTH'(r_last + 1'b1))
         w_kind = KIND_STEP;
      else if (r_cand == '0)
         w_kind = KIND_CLEAR;
   end

   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[PW-1] != r_rd[PW-1]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = !w_empty && ev_if.ev_ready;
   assign w_push  = w_accept && (!w_full || w_pop);
   assign w_drop  = w_accept && w_full && !w_pop;

   assign ev_if.ev_valid = !w_empty;
   assign ev_if.ev_data  = r_mem[r_rd[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_cand <= '0;
         r_last <= '0;
         r_stab <= STAB_SAT;
      end else begin
         r_s1 <= cnt_in;
         r_s2 <= r_s1;
         if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_stab <= '0;
         end else if (r_stab < STAB_SAT) begin
            r_stab <= SW'(r_stab + 1'b1);
         end
         if (w_accept)
            r_last <= r_cand;
      end
   end

   // Memory is cleared on reset so ev_data reads zero while nothing was ever queued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr <= '0;
         r_rd <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         if (w_pop)
            r_rd <= PW'(r_rd + 1'b1);
         if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= {w_kind, r_cand};
            r_wr <= PW'(r_wr + 1'b1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wrap <= '0;
         r_err  <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (clr_stats) begin
         r_wrap <= '0;
         r_err  <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_accept && w_kind == KIND_WRAP && r_wrap != {WRAPW{1'b1}})
            r_wrap <= WRAPW'(r_wrap + 1'b1);
         if (w_accept && w_kind == KIND_ERROR)
            r_err <= 1'b1;
         if (w_drop)
            r_ovf <= 1'b1;
      end
   end

   assign wrap_count = r_wrap;
   assign err_sticky = r_err;
   assign ovf_sticky = r_ovf;

endmodule

// File: tb/tb_count_stream_monitor.sv
// Bench for count_stream_monitor: directed table rows, corner sequences and a
// randomized run, all checked cycle by cycle against a run-length reference model.
module tb_count_stream_monitor;

   localparam int ST    = 3;
   localparam int DEPTH = 4;

   logic       clk;
   logic       reset;
   logic [3:0] cnt_in;
   logic       clr_stats;
   logic [7:0] wrap_count;
   logic       err_sticky;
   logic       ovf_sticky;

   count_stream_monitor_if #(.WIDTH(4)) ev_if ();

   count_stream_monitor #(
      .WIDTH(4), .STABLE_CYCLES(ST), .FIFO_DEPTH(DEPTH), .WRAPW(8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cnt_in     (cnt_in),
      .clr_stats  (clr_stats),
      .ev_if      (ev_if.master),
      .wrap_count (wrap_count),
      .err_sticky (err_sticky),
      .ovf_sticky (ovf_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // reference model: synchronized value stream as a delay queue, plus run length
   logic [3:0] dly[$];
   logic [3:0] run_val;
   int         run_len;
   logic [3:0] m_last;
   logic [5:0] mq[$];
   int         m_wrap;
   logic       m_err;
   logic       m_ovf;

   logic [5:0] dut_pops[$];

   typedef struct {
      logic [3:0] cnt;
      int         hold;
      logic       clr;
      int         n_ev;
      logic [5:0] ev;
      int         wrap;
      logic       err;
   } row_t;

   row_t rows[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      dly = {4'd0, 4'd0};
      run_val = 4'd0;
      run_len = 1000;
      m_last = 4'd0;
      mq = {};
      m_wrap = 0;
      m_err = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] c, input logic clr, input logic rdy);
      logic [3:0] x;
      logic [1:0] kind;
      x = dly.pop_front();
      dly.push_back(c);
      if (x == run_val) begin
         if (run_len < 1000) run_len++;
      end else begin
         run_val = x;
         run_len = 1;
      end
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (run_len == ST + 1 && run_val != m_last) begin
         if (int'(run_val) == (int'(m_last) + 1) % 16) kind = (m_last == 4'd15) ? 2'b01 : 2'b00;
         else if (run_val == 4'd0) kind = 2'b10;
         else kind = 2'b11;
         m_last = run_val;
         if (mq.size() < DEPTH) mq.push_back({kind, run_val});
         else if (!clr) m_ovf = 1'b1;
         if (kind == 2'b01 && m_wrap < 255) m_wrap++;
         if (kind == 2'b11) m_err = 1'b1;
      end
      if (clr) begin
         m_wrap = 0;
         m_err = 1'b0;
         m_ovf = 1'b0;
      end
   endtask

   task automatic check_outputs();
      chk("ev_valid", 32'(ev_if.ev_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("ev_data", 32'(ev_if.ev_data), 32'(mq[0]));
      chk("wrap_count", 32'(wrap_count), 32'(m_wrap));
      chk("err_sticky", 32'(err_sticky), 32'(m_err));
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
   endtask

   // Called at posedge+1; drives inputs for the next edge, then checks after it.
   task automatic cycle(input logic [3:0] c, input logic clr, input logic rdy);
      cnt_in = c;
      clr_stats = clr;
      ev_if.ev_ready = rdy;
      if (ev_if.ev_valid && rdy) dut_pops.push_back(ev_if.ev_data);
      model_step(c, clr, rdy);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clr_stats = 1'b0;
      ev_if.ev_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_ev_valid", 32'(ev_if.ev_valid), 32'd0);
      chk("rst_ev_data", 32'(ev_if.ev_data), 32'd0);
      chk("rst_stats", {wrap_count, err_sticky, ovf_sticky}, 32'd0);
      reset = 1'b1;
   endtask

   task automatic hold(input logic [3:0] c, input int n, input logic rdy);
      for (int i = 0; i < n; i++) cycle(c, 1'b0, rdy);
   endtask

   initial begin
      int p0;
      logic [3:0] v;
      logic [3:0] prev;
      int hl;

      // directed rows: {cnt, hold, clr, events popped in row, last popped, wrap, err}
      rows.push_back('{4'd1, 10, 1'b0, 1, 6'h01, 0, 1'b0});
      for (int k = 2; k <= 15; k++) rows.push_back('{4'(k), 8, 1'b0, 1, 6'(k), 0, 1'b0});
      rows.push_back('{4'd0, 8, 1'b0, 1, 6'h10, 1, 1'b0});
      for (int k = 1; k <= 3; k++) rows.push_back('{4'(k), 8, 1'b0, 1, 6'(k), 1, 1'b0});
      rows.push_back('{4'd7, 2, 1'b0, 0, 6'h00, 1, 1'b0});
      rows.push_back('{4'd3, 8, 1'b0, 0, 6'h00, 1, 1'b0});
      rows.push_back('{4'd4, 8, 1'b0, 1, 6'h04, 1, 1'b0});
      rows.push_back('{4'd5, 8, 1'b0, 1, 6'h05, 1, 1'b0});
      rows.push_back('{4'd9, 8, 1'b0, 1, 6'h39, 1, 1'b1});
      rows.push_back('{4'd0, 8, 1'b0, 1, 6'h20, 1, 1'b1});
      rows.push_back('{4'd0, 3, 1'b1, 0, 6'h00, 0, 1'b0});

      cnt_in = 4'd0;
      do_reset();
      foreach (rows[r]) begin
         p0 = dut_pops.size();
         for (int i = 0; i < rows[r].hold; i++) cycle(rows[r].cnt, rows[r].clr, 1'b1);
         chk($sformatf("row%0d_nev", r), 32'(dut_pops.size() - p0), 32'(rows[r].n_ev));
         if (rows[r].n_ev > 0 && dut_pops.size() > 0)
            chk($sformatf("row%0d_ev", r), 32'(dut_pops[dut_pops.size()-1]), 32'(rows[r].ev));
         chk($sformatf("row%0d_wrap", r), 32'(wrap_count), 32'(rows[r].wrap));
         chk($sformatf("row%0d_err", r), 32'(err_sticky), 32'(rows[r].err));
      end

      // overflow under backpressure, then in-order drain
      cnt_in = 4'd0;
      do_reset();
      for (int k = 1; k <= 5; k++) hold(4'(k), 8, 1'b0);
      chk("ovf_set", 32'(ovf_sticky), 32'd1);
      chk("ovf_head", 32'(ev_if.ev_data), 32'h01);
      p0 = dut_pops.size();
      hold(4'd5, 6, 1'b1);
      chk("drain_count", 32'(dut_pops.size() - p0), 32'd4);
      for (int i = 0; i < 4; i++)
         if (p0 + i < dut_pops.size()) chk("drain_order", 32'(dut_pops[p0+i]), 32'(i + 1));
      chk("drain_empty", 32'(ev_if.ev_valid), 32'd0);

      // push coinciding with pop while full: no drop
      cnt_in = 4'd0;
      do_reset();
      for (int k = 1; k <= 4; k++) hold(4'(k), 8, 1'b0);
      p0 = dut_pops.size();
      for (int i = 0; i < 8; i++) cycle(4'd5, 1'b0, (i == 5));
      chk("fullpop_ovf", 32'(ovf_sticky), 32'd0);
      hold(4'd5, 6, 1'b1);
      chk("fullpop_count", 32'(dut_pops.size() - p0), 32'd5);
      for (int i = 0; i < 5; i++)
         if (p0 + i < dut_pops.size()) chk("fullpop_order", 32'(dut_pops[p0+i]), 32'(i + 1));

      // asynchronous reset with events queued
      cnt_in = 4'd0;
      do_reset();
      for (int k = 1; k <= 3; k++) hold(4'(k), 8, 1'b0);
      chk("pre_rst_valid", 32'(ev_if.ev_valid), 32'd1);
      #3 reset = 1'b0;
      #1;
      chk("async_rst_valid", 32'(ev_if.ev_valid), 32'd0);
      chk("async_rst_stats", {wrap_count, err_sticky, ovf_sticky}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      p0 = dut_pops.size();
      hold(4'd1, 10, 1'b1);
      chk("post_rst_count", 32'(dut_pops.size() - p0), 32'd1);
      if (dut_pops.size() > p0) chk("post_rst_ev", 32'(dut_pops[p0]), 32'h01);

      // randomized run against the model
      cnt_in = 4'd0;
      do_reset();
      prev = 4'd0;
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: v = 4'(prev + 4'd1);
            6:                v = 4'd0;
            default:          v = 4'($urandom_range(0, 15));
         endcase
         hl = $urandom_range(1, 9);
         for (int i = 0; i < hl; i++)
            cycle(v, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));
         prev = v;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/count_stream_monitor.md
Name: count_stream_monitor

Overview:
- Downstream consumer of the 4-bit divided-clock counter output.
- Samples the counter value into the system clock domain and filters multi-bit transition skew.
- Classifies every accepted value change as step, wrap, clear or error.
- Queues classified events in a small FIFO with a valid/ready interface, and keeps wrap/error/overflow statistics.

Parameters:
- WIDTH, 4: width of the monitored count.
- STABLE_CYCLES, 3: consecutive equal synchronized samples required before a value is accepted (>=1).
- FIFO_DEPTH, 4: event FIFO entries (power of 2, >=2).
- WRAPW, 8: width of the wrap counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset; one clock; reset is asynchronous and active-low.
- cnt_in  in  WIDTH  counter value; driven from another clock, asynchronous to clk.
- clr_stats  in  1  synchronous clear of wrap_count, err_sticky, ovf_sticky.
- ev_valid  out  1  FIFO non-empty.
- ev_ready  in  1  consumer accepts the head event.
- ev_data  out  WIDTH+2  head event: [WIDTH+1:WIDTH] kind (00 step, 01 wrap, 10 clear, 11 error); [WIDTH-1:0] accepted value.
- wrap_count  out  WRAPW  saturating count of wrap events.
- err_sticky  out  1  set by any error event.
- ovf_sticky  out  1  set when an event is dropped on a full FIFO.

Behaviour:
- Reset (reset=0, asynchronous):
  - s1, s2, cand, last = 0; stab_cnt = STABLE_CYCLES (saturated, so no spurious accept).
  - FIFO emptied.
  - Outputs: ev_valid=0, ev_data=0, wrap_count=0, err_sticky=0, ovf_sticky=0.
  - Reset mid-operation discards queued events and any filter progress.
- Synchronizer: s1<=cnt_in, s2<=s1 every cycle.
- Filter, per edge:
  - if s2!=cand: cand<=s2, stab_cnt<=0.
  - else if stab_cnt<STABLE_CYCLES: stab_cnt++.
- Accept: on an edge where s2==cand, stab_cnt==STABLE_CYCLES-1 and cand!=last.
  - last<=cand; one event is pushed.
  - A value equal to last is never re-reported.
- Latency: a cnt_in change settled before edge 1 is accepted at edge 3+STABLE_CYCLES. ev_valid rises after that edge (edge 6 at default) when the FIFO was empty.
- Classification, with p=last and v=cand, mod 2^WIDTH:
  - WRAP if p==2^WIDTH-1 and v==0.
  - STEP if v==p+1 and p!=2^WIDTH-1.
  - CLEAR if v==0 otherwise.
  - ERROR in all other cases.
- Statistics:
  - WRAP increments wrap_count, saturating at 2^WRAPW-1.
  - ERROR sets err_sticky.
  - clr_stats has priority over a same-cycle increment or set. The event is still queued.
- FIFO:
  - Pop when ev_valid&ev_ready. ev_data is the head, registered, and holds stable while ev_valid=1 and ev_ready=0.
  - Push while full without a same-cycle pop: event dropped, ovf_sticky set (unless clr_stats), contents unchanged.
  - Push while full with a same-cycle pop: both occur, no drop.
  - Push and pop while empty: no bypass. The event appears on the next cycle.
  - Read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
- No combinational path from ev_ready to ev_valid or ev_data.

Test Plan:
- Basic step: after reset, cnt_in 0->1 held 10 cycles, ev_ready=1 -> exactly one event {00,1}; ev_valid rises 6 cycles after the change and stays high for 1 cycle.
- Full wrap sweep: cnt_in 1..15 then 0, each held 8 cycles, ev_ready=1 -> 14 STEP events, then {01,0}; wrap_count=1; err_sticky=0.
- Glitch rejection: cnt_in 3->7 for 2 cycles, then back to 3 (last=3) -> no event. Then 3->4 held 8 cycles -> {00,4}.
- Error and clear: last=5; cnt_in=9 -> {11,9}, err_sticky=1. Then cnt_in=0 -> {10,0}. Then clr_stats pulse -> err_sticky=0, wrap_count=0.
- Overflow/backpressure:
  - ev_ready=0; drive 5 step changes 1..5 -> FIFO holds {1,2,3,4}, 5 dropped, ovf_sticky=1, ev_data stays {00,1}.
  - Raise ev_ready -> 1,2,3,4 delivered in order, then ev_valid=0.
  - Separately, a push coinciding with a pop while full -> no drop.
- Reset mid-operation: 3 events queued; assert reset asynchronously between edges -> ev_valid=0 immediately, all stats 0. After release, cnt_in=1 held -> {00,1}.
